// File: rtl/mem_dump.sv
// mem_dump: walks a page-aligned block of memory and streams every word out
// over a valid/ready handshake, tagging the last word of each display row and
// the last word of the whole dump.
//
// Ports
//   clk, reset            clock and synchronous active-high reset
//   start, abort          begin a dump (IDLE only) / cancel a dump in flight
//   base_addr, npages     dump origin (rounded down to a page) and page count
//   mem_rd, mem_addr      read strobe and address to the memory
//   mem_data              read data, valid the cycle after mem_rd
//   out_valid/out_ready   output handshake
//   out_data, out_addr    dumped word and its address
//   out_eor, out_last     end-of-row / end-of-dump markers
//   busy, done            activity flag and one-cycle completion pulse
module mem_dump #(
    parameter int DW        = 16,
    parameter int AW        = 16,
    parameter int PAGE_BITS = 8,
    parameter int ROW_BITS  = 4,
    parameter int MAX_PAGES = 4,
    parameter int NW        = $clog2(MAX_PAGES + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          abort,
    input  logic [AW-1:0] base_addr,
    input  logic [NW-1:0] npages,
    output logic          mem_rd,
    output logic [AW-1:0] mem_addr,
    input  logic [DW-1:0] mem_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [AW-1:0] out_addr,
    output logic          out_eor,
    output logic          out_last,
    output logic          busy,
    output logic          done
);

    // remaining holds up to MAX_PAGES * 2^PAGE_BITS, which fits NW+PAGE_BITS bits
    localparam int RW = NW + PAGE_BITS;
    localparam logic [NW-1:0] MAXP = NW'(MAX_PAGES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_HOLD,
        S_DONE
    } state_t;

    state_t        state, state_nxt;
    logic [AW-1:0] cur;
    logic [RW-1:0] remaining;
    logic          hs;
    logic          npages_bad;

    // Offset-within-page bits of base_addr are deliberately dropped.
    logic unused_base_lo;
    assign unused_base_lo = ^base_addr[PAGE_BITS-1:0];

    assign hs         = out_valid && out_ready;
    assign npages_bad = (npages == '0) || (npages > MAXP);
    assign mem_addr   = cur;

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        mem_rd    = 1'b0;
        done      = 1'b0;
        busy      = (state != S_IDLE);
        case (state)
            S_IDLE: if (start) state_nxt = npages_bad ? S_DONE : S_READ;
            S_READ: begin
                mem_rd    = 1'b1;
                state_nxt = S_WAIT;
            end
            S_WAIT: state_nxt = S_HOLD;
            S_HOLD: if (hs) state_nxt = (remaining > RW'(1)) ? S_READ : S_DONE;
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
        // abort wins over everything, including start and a pending handshake
        if (abort) begin
            state_nxt = S_IDLE;
            mem_rd    = 1'b0;
            done      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cur       <= '0;
            remaining <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_addr  <= '0;
            out_eor   <= 1'b0;
            out_last  <= 1'b0;
        end else if (abort) begin
            out_valid <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    cur       <= {base_addr[AW-1:PAGE_BITS], {PAGE_BITS{1'b0}}};
                    remaining <= {npages, {PAGE_BITS{1'b0}}};
                end
                // mem_data answers the read issued in the previous cycle
                S_WAIT: begin
                    out_data  <= mem_data;
                    out_addr  <= cur;
                    out_valid <= 1'b1;
                    out_eor   <= &cur[ROW_BITS-1:0];
                    out_last  <= (remaining == RW'(1));
                end
                S_HOLD: if (hs) begin
                    out_valid <= 1'b0;
                    cur       <= cur + AW'(1);
                    remaining <= remaining - RW'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/mem_dump.md
MEM_DUMP -- requirements
Module: mem_dump

Interface
REQ-001 SHALL have parameter DW, default 16, memory data width in bits.
REQ-002 SHALL have parameter AW, default 16, memory word-address width in bits.
REQ-003 SHALL have parameter PAGE_BITS, default 8, log2 of words per page.
REQ-004 SHALL have parameter ROW_BITS, default 4, log2 of words per display row.
REQ-005 SHALL have parameter MAX_PAGES, default 4, largest legal page count per dump.
REQ-006 SHALL have parameter NW, default clog2(MAX_PAGES+1), width of npages.
REQ-007 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-008 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-009 SHALL have port start  input  1  request a dump; sampled only in IDLE.
REQ-010 SHALL have port abort  input  1  cancel any dump in progress.
REQ-011 SHALL have port base_addr  input  AW  start address; low PAGE_BITS bits ignored.
REQ-012 SHALL have port npages  input  NW  pages to dump.
REQ-013 SHALL have port mem_rd  output  1  memory read strobe.
REQ-014 SHALL have port mem_addr  output  AW  memory read address.
REQ-015 SHALL have port mem_data  input  DW  read data, valid exactly 1 cycle after mem_rd.
REQ-016 SHALL have port out_valid  output  1  out_data/out_addr hold a word.
REQ-017 SHALL have port out_ready  input  1  consumer accepts the word.
REQ-018 SHALL have port out_data  output  DW  dumped word.
REQ-019 SHALL have port out_addr  output  AW  address of out_data.
REQ-020 SHALL have port out_eor  output  1  word is the last of its row.
REQ-021 SHALL have port out_last  output  1  word is the last of the dump.
REQ-022 SHALL have port busy  output  1  high in any state except IDLE.
REQ-023 SHALL have port done  output  1  one-cycle completion pulse.

Function
REQ-024 SHALL implement states IDLE, READ, WAIT, HOLD, DONE.
REQ-025 IDLE + start: SHALL latch cur=base_addr & ~(2^PAGE_BITS-1), remaining=npages*2^PAGE_BITS words, go to READ; npages=0 or >MAX_PAGES goes straight to DONE, no reads.
REQ-026 READ: SHALL assert mem_rd=1, mem_addr=cur for exactly one cycle, then go to WAIT.
REQ-027 WAIT: SHALL register mem_data into out_data, cur into out_addr, set out_valid, out_eor=(cur low ROW_BITS all ones), out_last=(remaining==1); go to HOLD.
REQ-028 HOLD: out_valid and out_data/out_addr/out_eor/out_last SHALL stay stable until out_valid&&out_ready.
REQ-029 On handshake: out_valid drops next cycle; cur increments modulo 2^AW (0xFFFF wraps to 0x0000); remaining decrements; go to READ if remaining>0, else DONE.
REQ-030 Peak throughput SHALL be one word per 3 cycles with out_ready held high.
REQ-031 DONE: done=1 for exactly one cycle, then IDLE.
REQ-032 start outside IDLE SHALL be ignored; base_addr/npages SHALL only be sampled on the accepted start.
REQ-033 abort in any non-IDLE state SHALL force IDLE next cycle, clear out_valid, suppress done and mem_rd; abort beats a same-cycle handshake; abort in IDLE beats start.
REQ-034 mem_rd SHALL be 0 in all states except READ.

Reset
REQ-035 reset SHALL dominate start/abort and, next edge, give IDLE, mem_rd=0, mem_addr=0, out_valid=0, out_data=0, out_addr=0, out_eor=0, out_last=0, busy=0, done=0.
REQ-036 reset mid-dump SHALL discard the dump; no done pulse.

Verification
REQ-037 base_addr=0x0312, npages=1, out_ready=1 -> 256 words at 0x0300..0x03FF in order, out_eor on 0x030F/0x031F/..., out_last only on 0x03FF, one done pulse.
REQ-038 npages=4, base 0x0000, out_ready random 50% -> 1024 words matching preloaded memory, no address skipped/repeated, out_data stable during stalls.
REQ-039 base_addr=0xFF00, npages=2 -> addresses 0xFF00..0xFFFF then 0x0000..0x00FF, done after 512 words.
REQ-040 npages=0 and npages=5 (MAX_PAGES=4) -> zero mem_rd, busy 1 cycle, done pulse.
REQ-041 abort asserted during HOLD of word 10 with out_ready=1 -> handshake not counted, out_valid=0 and IDLE next cycle, no done; fresh start then works.
REQ-042 reset asserted in WAIT, also start held -> IDLE with all outputs 0 next cycle; start accepted only after reset deasserts.
